// File: rtl/if_fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_fetch_pkg                                                          |
// | Shared types and constants for the instruction-fetch stage.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package if_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_fetch_buf                                                          |
// | FB_DEPTH-entry synchronous FIFO of {pc4, inst} fetch entries.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module if_fetch_buf
  import if_fetch_pkg::*;
#(
  parameter int FB_DEPTH = 2,
  localparam int AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1,
  localparam int CW = $clog2(FB_DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          i_push,
  input  fb_entry_t     i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output fb_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

  fb_entry_t     r_mem [FB_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage needs no reset: the head is only consumed when count is non-zero.
  always_ff @(posedge Clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_fetch_unit                                                         |
// | PC/fetch FSM feeding IF/ID; optional perf counters: IF_FETCH_PERF_EN. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FB_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic        ID_stall,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] PC_4,
  output logic [31:0] Inst,
  output logic        Inst_Valid,
  output logic        IF_Flush,
  output logic        IF_stall,
  output logic [31:0] Bubble_Cnt,
  output logic [15:0] Redirect_Cnt
);

  localparam int            CW      = $clog2(FB_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_drain_addr;
  logic          r_run;

  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pc_next;
  logic [31:0]   w_target;
  fb_entry_t     w_push_data;
  fb_entry_t     w_head;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;

  // r_run keeps the request low until the first edge after reset release.
  assign w_req       = r_run & ((r_state == DRAIN) | (w_count < DEPTH_C));
  assign w_pc_next   = r_pc + PC_INCR;
  assign w_target    = {Redirect_PC[31:2], 2'b00};
  assign w_push_data = {w_pc_next, Imem_Data};
  assign w_push      = (r_state == FETCH) & w_req & Imem_Ack & ~Redirect & ~w_full;
  assign w_pop       = ~Redirect & ~ID_stall & ~w_empty;

  assign Imem_Req  = w_req;
  assign Imem_Addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

  if_fetch_buf #(
    .FB_DEPTH (FB_DEPTH)
  ) u_buf (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_clear (Redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_run        <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        FETCH: begin
          if (Redirect) begin
            r_pc <= w_target;
            // The in-flight request must still complete at its old address.
            if (w_req && !Imem_Ack) begin
              r_state      <= DRAIN;
              r_drain_addr <= r_pc;
            end
          end else if (w_req && Imem_Ack) begin
            r_pc <= w_pc_next;
          end
        end
        DRAIN: begin
          if (Redirect) begin
            r_pc <= w_target;
          end
          if (Imem_Ack) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    IF_Flush = 1'b0;
    IF_stall = 1'b0;
    if (Redirect) begin
      IF_Flush = 1'b1;
    end else if (ID_stall) begin
      IF_stall = 1'b1;
    end else if (w_empty) begin
      IF_Flush = 1'b1;
    end
  end

  assign Inst_Valid = ~w_empty;
  assign Inst       = w_empty ? NOP_INST : w_head.inst;
  assign PC_4       = w_empty ? 32'h0000_0000 : w_head.pc4;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [15:0] r_redirect_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bubble_cnt   <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (IF_Flush && !Redirect && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (Redirect) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

  assign Bubble_Cnt   = r_bubble_cnt;
  assign Redirect_Cnt = r_redirect_cnt;
`else
  assign Bubble_Cnt   = 32'h0000_0000;
  assign Redirect_Cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_if_fetch_unit                                                      |
// | Directed table-driven bench for if_fetch_unit (data returned = addr). |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = 32'h0;
  logic        ID_stall = 1'b0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] PC_4;
  logic [31:0] Inst;
  logic        Inst_Valid;
  logic        IF_Flush;
  logic        IF_stall;
  logic [31:0] Bubble_Cnt;
  logic [15:0] Redirect_Cnt;

  logic        auto_ack = 1'b1;
  logic        man_ack = 1'b0;

  logic        Rst_w_n = 1'b0;
  logic        Req_w;
  logic [31:0] Addr_w;
  logic        Ack_w;
  logic [31:0] Data_w;
  logic [31:0] PC_4_w;
  logic [31:0] Inst_w;
  logic        Valid_w;
  logic        Flush_w;
  logic        Stall_w;
  logic [31:0] Bub_w;
  logic [15:0] Red_w;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  assign Imem_Ack  = auto_ack ? Imem_Req : man_ack;
  assign Imem_Data = Imem_Addr;
  assign Ack_w     = Req_w;
  assign Data_w    = Addr_w;

  if_fetch_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .ID_stall(ID_stall), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data), .PC_4(PC_4), .Inst(Inst),
    .Inst_Valid(Inst_Valid), .IF_Flush(IF_Flush), .IF_stall(IF_stall),
    .Bubble_Cnt(Bubble_Cnt), .Redirect_Cnt(Redirect_Cnt)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .Clk(Clk), .Rst_n(Rst_w_n), .Redirect(1'b0), .Redirect_PC(32'h0),
    .ID_stall(1'b0), .Imem_Req(Req_w), .Imem_Addr(Addr_w),
    .Imem_Ack(Ack_w), .Imem_Data(Data_w), .PC_4(PC_4_w), .Inst(Inst_w),
    .Inst_Valid(Valid_w), .IF_Flush(Flush_w), .IF_stall(Stall_w),
    .Bubble_Cnt(Bub_w), .Redirect_Cnt(Red_w)
  );

  typedef struct {
    bit          rst;
    bit          aack;
    bit          ack;
    bit          redir;
    logic [31:0] rpc;
    bit          stall;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc4;
    bit          e_flush;
    bit          e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit aack, input bit ack, input bit redir,
                     input logic [31:0] rpc, input bit stall, input bit e_req,
                     input logic [31:0] e_addr, input bit e_valid,
                     input logic [31:0] e_pc4, input bit e_flush, input bit e_stall);
    vec_t v;
    v.rst = rst; v.aack = aack; v.ack = ack; v.redir = redir; v.rpc = rpc;
    v.stall = stall; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc4 = e_pc4; v.e_flush = e_flush; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  // Ends at a falling edge with reset released; checks reset-state outputs.
  task automatic do_reset();
    @(negedge Clk);
    Redirect = 1'b0;
    ID_stall = 1'b0;
    man_ack  = 1'b0;
    Rst_n    = 1'b0;
    #1;
    chk("rst_req", {31'b0, Imem_Req}, 32'h0);
    chk("rst_addr", Imem_Addr, 32'h0);
    chk("rst_valid", {31'b0, Inst_Valid}, 32'h0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_pc4", PC_4, 32'h0);
    chk("rst_flush", {31'b0, IF_Flush}, 32'h1);
    chk("rst_stall", {31'b0, IF_stall}, 32'h0);
    chk("rst_bub", Bubble_Cnt, 32'h0);
    chk("rst_red", {16'b0, Redirect_Cnt}, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    // rst aack ack redir rpc stall | req addr valid pc4 flush stall
    // zero-wait stream from reset
    add(1, 1, 0, 0, 32'h0,   0,  0, 32'h000, 0, 32'h000, 1, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h000, 0, 32'h000, 1, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h004, 1, 32'h004, 0, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h008, 1, 32'h008, 0, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h00C, 1, 32'h00C, 0, 0);
    // three stall cycles fill the buffer, then resume
    add(0, 1, 0, 0, 32'h0,   1,  1, 32'h010, 1, 32'h010, 0, 1);
    add(0, 1, 0, 0, 32'h0,   1,  0, 32'h014, 1, 32'h010, 0, 1);
    add(0, 1, 0, 0, 32'h0,   1,  0, 32'h014, 1, 32'h010, 0, 1);
    add(0, 1, 0, 0, 32'h0,   0,  0, 32'h014, 1, 32'h010, 0, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h014, 1, 32'h014, 0, 0);
    // redirect coincident with ack
    add(0, 1, 0, 1, 32'h200, 0,  1, 32'h018, 1, 32'h018, 1, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h200, 0, 32'h000, 1, 0);
    add(0, 1, 0, 0, 32'h0,   0,  1, 32'h204, 1, 32'h204, 0, 0);
    // 3-cycle memory, redirect to 0x103 while request 8 outstanding
    add(1, 0, 0, 0, 32'h0,   0,  0, 32'h000, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h000, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h000, 0, 32'h000, 1, 0);
    add(0, 0, 1, 0, 32'h0,   0,  1, 32'h000, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h004, 1, 32'h004, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h004, 0, 32'h000, 1, 0);
    add(0, 0, 1, 0, 32'h0,   0,  1, 32'h004, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h008, 1, 32'h008, 0, 0);
    add(0, 0, 0, 1, 32'h103, 0,  1, 32'h008, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h008, 0, 32'h000, 1, 0);
    add(0, 0, 1, 0, 32'h0,   0,  1, 32'h008, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h100, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h100, 0, 32'h000, 1, 0);
    add(0, 0, 1, 0, 32'h0,   0,  1, 32'h100, 0, 32'h000, 1, 0);
    add(0, 0, 0, 0, 32'h0,   0,  1, 32'h104, 1, 32'h104, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        auto_ack = vecs[i].aack;
        do_reset();
      end else begin
        @(negedge Clk);
      end
      auto_ack    = vecs[i].aack;
      man_ack     = vecs[i].ack;
      Redirect    = vecs[i].redir;
      Redirect_PC = vecs[i].rpc;
      ID_stall    = vecs[i].stall;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, Imem_Req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), Imem_Addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, Inst_Valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_pc4", i), PC_4, vecs[i].e_pc4);
      chk($sformatf("v%0d_inst", i), Inst,
          vecs[i].e_valid ? vecs[i].e_pc4 - 32'd4 : 32'h0);
      chk($sformatf("v%0d_flush", i), {31'b0, IF_Flush}, {31'b0, vecs[i].e_flush});
      chk($sformatf("v%0d_stall", i), {31'b0, IF_stall}, {31'b0, vecs[i].e_stall});
    end

    // PC wrap from RESET_PC = FFFF_FFF8
    @(negedge Clk);
    Rst_w_n = 1'b1;
    #1;
    chk("wrap_c0_req", {31'b0, Req_w}, 32'h0);
    chk("wrap_c0_addr", Addr_w, 32'hFFFF_FFF8);
    @(negedge Clk); #1;
    chk("wrap_c1_req", {31'b0, Req_w}, 32'h1);
    chk("wrap_c1_addr", Addr_w, 32'hFFFF_FFF8);
    @(negedge Clk); #1;
    chk("wrap_c2_addr", Addr_w, 32'hFFFF_FFFC);
    chk("wrap_c2_pc4", PC_4_w, 32'hFFFF_FFFC);
    @(negedge Clk); #1;
    chk("wrap_c3_addr", Addr_w, 32'h0000_0000);
    chk("wrap_c3_valid", {31'b0, Valid_w}, 32'h1);
    chk("wrap_c3_pc4", PC_4_w, 32'h0000_0000);
    chk("wrap_c3_inst", Inst_w, 32'hFFFF_FFFC);
    @(negedge Clk); #1;
    chk("wrap_c4_addr", Addr_w, 32'h0000_0004);

    // 5 empty cycles then 2 back-to-back redirects with no ack
    auto_ack = 1'b0;
    do_reset();
    repeat (5) @(negedge Clk);
    Redirect    = 1'b1;
    Redirect_PC = 32'h40;
    @(negedge Clk);
    Redirect_PC = 32'h80;
    @(negedge Clk);
    Redirect = 1'b0;
    #1;
`ifdef IF_FETCH_PERF_EN
    chk("perf_bubble", Bubble_Cnt, 32'd5);
    chk("perf_redirect", {16'b0, Redirect_Cnt}, 32'd2);
`else
    chk("perf_bubble", Bubble_Cnt, 32'd0);
    chk("perf_redirect", {16'b0, Redirect_Cnt}, 32'd0);
`endif
    chk("drain_req", {31'b0, Imem_Req}, 32'h1);
    chk("drain_addr", Imem_Addr, 32'h0);
    man_ack = 1'b1;
    @(negedge Clk);
    man_ack = 1'b0;
    #1;
    chk("post_drain_addr", Imem_Addr, 32'h80);
    chk("post_drain_req", {31'b0, Imem_Req}, 32'h1);
    chk("post_drain_valid", {31'b0, Inst_Valid}, 32'h0);
    chk("post_drain_flush", {31'b0, IF_Flush}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the program counter, issues requests to instruction memory, buffers returned words, and drives the `PC_4`/`Inst`/`IF_Flush`/`IF_stall` inputs of the IF/ID pipeline register. It sits between instruction memory and IF/ID and is the producer end of the fetch-to-decode interface. It also accepts branch/jump redirects resolved in ID and squashes wrong-path instructions.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `FB_DEPTH`, default 2: fetch-buffer entries; power of two, ≥2.

Ports:
- `Clk`  in  1  single clock; all state updates on posedge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Redirect`  in  1  branch/jump taken; load new PC.
- `Redirect_PC`  in  32  target; bits [1:0] are ignored and forced to 0.
- `ID_stall`  in  1  decode stalled; the presented instruction is held.
- `Imem_Req`  out  1  memory request valid.
- `Imem_Addr`  out  32  request word address; stable while `Imem_Req` is high and not yet acked.
- `Imem_Ack`  in  1  request accepted, with `Imem_Data` valid in the same cycle.
- `Imem_Data`  in  32  instruction word.
- `PC_4`  out  32  PC+4 of the presented instruction.
- `Inst`  out  32  presented instruction; 0 when no entry is valid.
- `Inst_Valid`  out  1  buffer head valid.
- `IF_Flush`  out  1  IF/ID loads a bubble this edge.
- `IF_stall`  out  1  IF/ID holds this edge.
- `Bubble_Cnt`  out  32  performance counter; see Configuration.
- `Redirect_Cnt`  out  16  performance counter; see Configuration.

## Operation

- FSM states: `FETCH`, `DRAIN`.
  - `FETCH`: `Imem_Req = (count < FB_DEPTH)` and `Imem_Addr = pc_q`. At most one request is outstanding.
  - On `Imem_Ack` in `FETCH`: push {pc_q+4, `Imem_Data`} into the buffer and set pc_q <= pc_q+4. The PC wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
  - Redirect while a request is outstanding and not acked: pc_q <= Redirect_PC and go to `DRAIN`. In `DRAIN`, `Imem_Req` stays high with the old address until ack. The acked data is discarded, then the FSM returns to `FETCH`.
  - Redirect in the same cycle as `Imem_Ack`: discard the data, pc_q <= Redirect_PC, stay in `FETCH`.
  - Redirect while no request is outstanding: pc_q <= Redirect_PC, stay in `FETCH`.
  - Redirect during `DRAIN`: pc_q is overwritten with the latest target.
- Redirect always clears the buffer (count <= 0) in the same edge.
- Output decode, combinational, evaluated in priority order:
  1. `Redirect`: `IF_Flush=1`, `IF_stall=0`.
  2. `ID_stall`: `IF_Flush=0`, `IF_stall=1`.
  3. Buffer empty: `IF_Flush=1`, `IF_stall=0`.
  4. Otherwise: `IF_Flush=0`, `IF_stall=0`, and the head entry is popped this edge.
- Simultaneous push and pop leaves count unchanged. A push while full cannot occur because no request is issued when full.

## Timing

- While `Rst_n` is low: pc_q=`RESET_PC`, FSM in `FETCH`, count=0. Outputs: `Imem_Req=0`, `Imem_Addr=RESET_PC`, `Inst_Valid=0`, `Inst=0`, `PC_4=0`, `IF_Flush=1`, `IF_stall=0`, counters 0.
- First `Imem_Req` is asserted in the first cycle after `Rst_n` rises.
- Ack at edge N: the entry is visible (`Inst_Valid=1`) from after edge N, and IF/ID captures it at edge N+1. Fetch-to-IF/ID latency is therefore 1 cycle after ack.
- With zero-wait memory (ack in the request cycle) and no stalls, throughput is 1 instruction per cycle.
- Redirect at edge N: the first correct-path request is issued in cycle N+1, or in the cycle after the drain ack if a request was outstanding.
- Reset asserted mid-request: `Imem_Req` drops immediately and the outstanding request is abandoned. The memory side must tolerate this.

## Configuration

- `IF_FETCH_PERF_EN` defined:
  - `Bubble_Cnt` increments every cycle in which `IF_Flush=1` and `Redirect=0`; it saturates at 32'hFFFF_FFFF.
  - `Redirect_Cnt` increments on every `Redirect` cycle and wraps.
  - Both counters are reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure

- `if_fetch_pkg`: FSM state enum, `NOP_INST = 32'h0`, `PC_INCR = 32'd4`.
- Sub-module `if_fetch_buf`: FB_DEPTH-entry synchronous FIFO of 64-bit {pc4, inst} entries.
  - Inputs: push, pop, clear.
  - Outputs: head, count, empty, full.
  - Same clock/reset as the parent.
- FSM, PC and output decode stay in `if_fetch_unit`.

## Test plan

- Reset release, zero-wait memory returning `Imem_Data = addr`, no stalls: `Imem_Addr` steps 0, 4, 8, … each cycle; `PC_4` = 4, 8, …; `IF_Flush` = 1 only in the first cycle.
- `ID_stall=1` for 3 cycles with FB_DEPTH=2: `IF_stall=1`, `Inst` held; `Imem_Req` drops once count=2; fetch resumes the cycle after the stall clears, with no lost or duplicated PC.
- Memory with 3-cycle ack latency, `Redirect` to 32'h0000_0103 on the cycle after request 8 is issued: `Imem_Addr` held at 8 until ack, data discarded, next request at 32'h100, `IF_Flush=1` until the 32'h100 word arrives.
- `Redirect` coincident with `Imem_Ack`: acked data dropped, next cycle `Imem_Addr` = target, buffer empty.
- Start at `RESET_PC` = 32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; `PC_4` of the FFFF_FFFC instruction is 0.
- `IF_FETCH_PERF_EN` defined, 5 empty cycles plus 2 redirects: `Bubble_Cnt`=5, `Redirect_Cnt`=2. Without the macro both read 0.
